// File: rtl/fetch_pkg.sv
// fetch_pkg: constants shared by the fetch sequencer, instruction memory and
// decode stage.
//   FETCH_ADDR_W      - program counter / memory address width
//   FETCH_DATA_W      - instruction width
//   FETCH_HALT_OPCODE - default opcode that ends a program
//   ST_*              - fetch_sequencer state encoding
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;

  localparam logic [7:0] FETCH_HALT_OPCODE = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: single-entry valid/ready holding register between fetch and
// decode.
//   clk, reset          - clock, synchronous active-high reset
//   load                - capture in_data/in_pc this edge
//   flush               - drop the held entry (wins over load)
//   in_data, in_pc      - instruction and its address to capture
//   ready               - downstream accepts the held entry
//   valid, data, pc     - held entry
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      pc    <= in_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, shares the instruction memory
// port between the program loader and fetch, and hands fetched bytes to
// decode over valid/ready.
//   clk, reset                      - clock, synchronous active-high reset
//   start                           - begin fetching at RESET_PC (idle/halt)
//   load_en, load_addr, load_data   - program loader write (idle/halt)
//   mem_addr, mem_wdata, mem_we     - instruction memory port
//   mem_rdata                       - combinational read data
//   instr_valid/ready/data/pc       - handshake to decode
//   branch_taken, branch_target     - redirect from execute
//   busy, halted, fault             - status
//
// state | meaning
// IDLE  | loader owns memory, waiting for start
// FETCH | fetching one byte per cycle into the output register
// DRAIN | last byte fetched, waiting for decode to take it
// HALT  | program ended (halted) or bad branch (fault); loader owns memory
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter int                MEM_DEPTH   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = FETCH_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;

  logic idle_like;
  logic active;
  logic flush;
  logic cap;
  logic accept;
  logic last_fetch;
  logic target_ok;
  logic load_ok;

  always_comb begin
    idle_like  = (state == ST_IDLE) || (state == ST_HALT);
    active     = (state == ST_FETCH) || (state == ST_DRAIN);
    flush      = active && branch_taken;
    accept     = instr_valid && instr_ready;
    cap        = (state == ST_FETCH) && !branch_taken && (!instr_valid || instr_ready);
    last_fetch = (mem_rdata == HALT_OPCODE) || (pc == LAST_PC);
    target_ok  = {1'b0, branch_target} < DEPTH_EXT;
    load_ok    = {1'b0, load_addr} < DEPTH_EXT;
  end

  always_comb begin
    mem_addr  = idle_like ? load_addr : pc;
    mem_wdata = load_data;
    // Reset also gates the write so a loader strobe during reset is dropped.
    mem_we    = !reset && load_en && idle_like && load_ok;
    busy      = active;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          // A loader write in the same cycle wins; start is dropped.
          if (start && !load_en) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            halted <= 1'b0;
            fault  <= 1'b0;
          end
        end
        ST_FETCH, ST_DRAIN: begin
          if (branch_taken) begin
            if (target_ok) begin
              pc    <= branch_target;
              state <= ST_FETCH;
            end else begin
              state <= ST_HALT;
              fault <= 1'b1;
            end
          end else if (state == ST_FETCH) begin
            if (cap) begin
              // pc saturates at the last location so the address bus never
              // points past the program while draining.
              if (pc != LAST_PC) pc <= pc + ADDR_W'(1);
              if (last_fetch) state <= ST_DRAIN;
            end
          end else if (accept) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (cap),
    .flush   (flush),
    .in_data (mem_rdata),
    .in_pc   (pc),
    .ready   (instr_ready),
    .valid   (instr_valid),
    .data    (instr_data),
    .pc      (instr_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = '0;
  logic       busy;
  logic       halted;
  logic       fault;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault)
  );

  // Instruction memory: combinational read, synchronous write.
  logic [7:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] prog [0:DEPTH-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = 8'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_prog_a();
    prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
    prog[3] = 8'hFF; prog[4] = 8'h55; prog[5] = 8'h66;
  endtask

  // Reference: the program delivers bytes from address 0 upward, stopping
  // after the first FF byte or the last location. Decode must see exactly
  // that sequence, in order, whatever the ready pattern.
  task automatic run_prog(input bit rand_ready);
    logic [15:0] expq[$];
    logic [15:0] e;
    int i;
    int cycles;
    bit done;
    bit hold;
    logic [7:0] hpc;
    logic [7:0] hdata;
    i = 0;
    while (1) begin
      expq.push_back({8'(i), prog[i]});
      if (prog[i] == 8'hFF || i == DEPTH - 1) break;
      i++;
    end
    pulse_start();
    cycles = 0;
    done = 0;
    hold = 0;
    hpc = '0;
    hdata = '0;
    while (!done && cycles < 300) begin
      instr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (busy) check("mem_addr_in_range", 32'(mem_addr < 8'(DEPTH)), 1);
      if (hold) begin
        check("stall_valid", instr_valid, 1);
        check("stall_pc", instr_pc, hpc);
        check("stall_data", instr_data, hdata);
      end
      if (instr_valid && instr_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_delivery observed pc=%0h expected none", instr_pc);
        end else begin
          e = expq.pop_front();
          check("deliver_pc", instr_pc, e[15:8]);
          check("deliver_data", instr_data, e[7:0]);
        end
      end
      hold  = instr_valid && !instr_ready;
      hpc   = instr_pc;
      hdata = instr_data;
      tick();
      cycles++;
      if (halted || fault) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL run_timeout observed halted=%0d expected halted=1", halted);
    end
    check("undelivered_left", expq.size(), 0);
    check("run_halted", halted, 1);
    check("run_busy", busy, 0);
    check("run_fault", fault, 0);
    instr_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset, with a loader strobe that must not reach memory.
    reset = 1'b1;
    load_en = 1'b1;
    load_addr = 8'd0;
    load_data = 8'hEE;
    tick();
    check("reset_mem_we", mem_we, 0);
    tick();
    check("reset_valid", instr_valid, 0);
    check("reset_data", instr_data, 0);
    check("reset_pc", instr_pc, 0);
    check("reset_halted", halted, 0);
    check("reset_fault", fault, 0);
    check("reset_busy", busy, 0);
    load_en = 1'b0;
    reset = 1'b0;
    tick();

    // Program with a halt byte, ready held high: latency and throughput.
    set_prog_a();
    load_prog();
    instr_ready = 1'b1;
    pulse_start();
    check("start_valid0", instr_valid, 0);
    check("start_busy", busy, 1);
    #1;
    check("start_mem_addr", mem_addr, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("seq_valid", instr_valid, 1);
      check("seq_pc", instr_pc, k);
      check("seq_data", instr_data, prog[k]);
      tick();
    end
    check("seq_halted", halted, 1);
    check("seq_busy", busy, 0);
    check("seq_valid_end", instr_valid, 0);

    // Stall three cycles while instr_pc=1.
    pulse_start();
    tick();
    tick();
    check("stall_start_pc", instr_pc, 1);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold_valid", instr_valid, 1);
      check("stall_hold_pc", instr_pc, 1);
      check("stall_hold_data", instr_data, 8'h22);
      #1;
      check("stall_hold_addr", mem_addr, 2);
    end
    instr_ready = 1'b1;
    tick();
    check("resume_pc2", instr_pc, 2);
    check("resume_data2", instr_data, 8'h33);
    tick();
    check("resume_pc3", instr_pc, 3);
    check("resume_data3", instr_data, 8'hFF);
    tick();
    check("resume_halted", halted, 1);

    // Program with no halt byte, random ready.
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'(i + 1);
    load_prog();
    run_prog(1'b1);

    // Random programs with occasional halt bytes.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < DEPTH; i++)
        prog[i] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      load_prog();
      run_prog(1'b1);
    end

    // Branch back to 1 while pc 3 is held and not accepted.
    set_prog_a();
    load_prog();
    instr_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    tick();
    check("br_pre_pc", instr_pc, 3);
    instr_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 8'd1;
    tick();
    branch_taken = 1'b0;
    check("br_flush_valid", instr_valid, 0);
    check("br_busy", busy, 1);
    #1;
    check("br_mem_addr", mem_addr, 1);
    instr_ready = 1'b1;
    tick();
    check("br_valid", instr_valid, 1);
    check("br_pc", instr_pc, 1);
    check("br_data", instr_data, 8'h22);
    tick();
    check("br_pc2", instr_pc, 2);
    tick();
    check("br_pc3", instr_pc, 3);
    tick();
    check("br_halted", halted, 1);

    // Illegal target -> fault; branch in HALT ignored; start clears fault.
    pulse_start();
    tick();
    check("flt_pre_valid", instr_valid, 1);
    branch_taken = 1'b1;
    branch_target = 8'h09;
    tick();
    branch_taken = 1'b0;
    check("flt_valid", instr_valid, 0);
    check("flt_fault", fault, 1);
    check("flt_halted", halted, 0);
    check("flt_busy", busy, 0);
    branch_taken = 1'b1;
    branch_target = 8'd2;
    tick();
    branch_taken = 1'b0;
    check("flt_ignore_busy", busy, 0);
    check("flt_ignore_fault", fault, 1);
    pulse_start();
    check("flt_clear_fault", fault, 0);
    check("flt_restart_busy", busy, 1);
    tick();
    check("flt_restart_pc", instr_pc, 0);
    check("flt_restart_data", instr_data, 8'h11);

    // Reset mid-fetch.
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_data", instr_data, 0);
    check("mid_rst_pc", instr_pc, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;

    // start + load_en together: the load wins, state stays idle.
    load_en = 1'b1;
    load_addr = 8'd4;
    load_data = 8'h77;
    start = 1'b1;
    #1;
    check("sl_mem_we", mem_we, 1);
    tick();
    start = 1'b0;
    load_en = 1'b0;
    check("sl_busy", busy, 0);
    check("sl_written", mem[4], 8'h77);

    // Out-of-range loader write is dropped.
    load_en = 1'b1;
    load_addr = 8'd7;
    load_data = 8'h99;
    #1;
    check("oor_mem_we", mem_we, 0);
    tick();
    load_en = 1'b0;
    check("oor_not_written", mem[7], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
